mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 64, consecutive busy ACCESS cycles before abort (range 2..255).
REQ-002 CLK  in  1  clock; all state changes on rising edge.
REQ-003 RESET  in  1  reset, asynchronous, active-high.
REQ-004 REQ_READ  in  1  pipeline load request (MEM stage).
REQ-005 REQ_WRITE  in  1  pipeline store request.
REQ-006 REQ_FUNCT3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-007 REQ_ADDR  in  32  byte address.
REQ-008 REQ_WDATA  in  32  store data, right-aligned.
REQ-009 STALL  out  1  freeze pipeline, combinational.
REQ-010 RDATA  out  32  extended load result, registered.
REQ-011 RVALID  out  1  one-cycle pulse, load result valid.
REQ-012 FAULT  out  2  00 none, 01 misaligned, 10 illegal, 11 timeout; registered.
REQ-013 MEM_READ / MEM_WRITE  out  1 each  memory strobes, registered.
REQ-014 MEM_ADDRESS  out  32  word address, bits [1:0] always 0.
REQ-015 MEM_BYTE_EN  out  4  byte lanes written; 1111 for reads.
REQ-016 MEM_DATA_OUT  out  32  lane-replicated store data.
REQ-017 MEM_DATA_IN  in  32  read word from memory.
REQ-018 MEM_BUSYWAIT  in  1  memory busy; may rise combinationally with strobe.

Function
REQ-019 FSM states IDLE, ACCESS, DONE; exactly one active.
REQ-020 IDLE, REQ_READ or REQ_WRITE high: STALL=1 combinationally; request fields registered at edge.
REQ-021 IDLE -> ACCESS when request legal and aligned; MEM_READ or MEM_WRITE =1 throughout ACCESS.
REQ-022 IDLE -> DONE with FAULT=10 when both REQ_READ and REQ_WRITE high, or FUNCT3 not legal for the direction; no strobe.
REQ-023 IDLE -> DONE with FAULT=01 when H/HU with addr[0]=1 or W with addr[1:0]!=00; no strobe.
REQ-024 ACCESS: STALL=1; each edge with MEM_BUSYWAIT=0 -> DONE, load captures MEM_DATA_IN.
REQ-025 ACCESS: busy counter (8 bit) increments per edge with MEM_BUSYWAIT=1; at TIMEOUT_CYCLES -> DONE, FAULT=11, strobes drop, RDATA unchanged.
REQ-026 DONE: STALL=0, strobes 0, FAULT per REQ-022/023/025 else 00; unconditional -> IDLE; request lines ignored in DONE.
REQ-027 RVALID=1 only in DONE after successful load; stores complete silently.
REQ-028 Store lanes: B en=0001<<a[1:0], data={4{wd[7:0]}}; H en=0011 (a[1]=0) / 1100, data={2{wd[15:0]}}; W en=1111, data=wd.
REQ-029 Load extract: B/BU byte a[1:0]; H/HU half a[1]; sign-extend B/H, zero-extend BU/HU; W unchanged.
REQ-030 Minimum latency: request cycle 0, strobe cycle 1, DONE cycle 2 (zero-wait memory).
REQ-031 RDATA holds last successful load value until next successful load.
REQ-032 Counter cleared on every IDLE->ACCESS transition.

Reset
REQ-033 RESET high: state IDLE, all outputs 0, counter 0, request registers 0, immediately.
REQ-034 RESET during ACCESS: strobes drop same instant; no RVALID, no FAULT for aborted access.
REQ-035 First request accepted on first rising edge after RESET deasserts.

Verification
REQ-036 LW 0x10, BUSYWAIT high for first 3 ACCESS edges, word 0x8899AABB -> STALL high 5 cycles, RDATA=0x8899AABB, RVALID 1 cycle.
REQ-037 Word 0x8899AABB: LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088; LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
REQ-038 SH 0x22, wdata 0x1234ABCD -> MEM_ADDRESS 0x20, BYTE_EN 1100, DATA_OUT 0xABCDABCD; SB 0x21 -> BYTE_EN 0010, DATA_OUT 0xCDCDCDCD.
REQ-039 LW 0x06 -> FAULT=01 one cycle, MEM_READ never high; REQ_READ+REQ_WRITE -> FAULT=10; SBU (101 store) -> FAULT=10.
REQ-040 BUSYWAIT stuck high, LW 0x40 -> after 64 ACCESS edges FAULT=11, MEM_READ low, RVALID 0, STALL low in DONE.
REQ-041 RESET pulse mid-ACCESS -> MEM_READ/MEM_WRITE 0 at once, no RVALID; next LW 0x10 completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store sequencer. Checks alignment and
//               legality, drives word-addressed memory strobes with byte
//               lanes, waits on a busy handshake with a timeout, and
//               returns sign/zero-extended load data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_READ,
  input  logic        REQ_WRITE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        STALL,
  output logic [31:0] RDATA,
  output logic        RVALID,
  output logic [1:0]  FAULT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDRESS,
  output logic [3:0]  MEM_BYTE_EN,
  output logic [31:0] MEM_DATA_OUT,
  input  logic [31:0] MEM_DATA_IN,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Count value reached on the last busy edge that may still be tolerated.
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_stall;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_alo;
  logic        r_load;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic [1:0]  r_fault;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_byte_en;
  logic [31:0] r_data_out;

  logic        w_req;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request decode: legality, alignment and timeout detection.
  always_comb begin
    w_req      = REQ_READ | REQ_WRITE;
    w_illegal  = (REQ_READ & REQ_WRITE)
               | (REQ_READ  & ((REQ_FUNCT3[1:0] == 2'b11) || (REQ_FUNCT3 == 3'b110)))
               | (REQ_WRITE & (REQ_FUNCT3[2] || (REQ_FUNCT3[1:0] == 2'b11)));
    w_misalign = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0])
               | ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
    w_timeout  = MEM_BUSYWAIT && (r_cnt == c_TO_LAST);
  end

  // Store lane enables and lane-replicated store data.
  always_comb begin
    w_st_be   = 4'hF;
    w_st_data = REQ_WDATA;
    case (REQ_FUNCT3[1:0])
      2'b00: begin
        w_st_be   = 4'b0001 << REQ_ADDR[1:0];
        w_st_data = {4{REQ_WDATA[7:0]}};
      end
      2'b01: begin
        w_st_be   = REQ_ADDR[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{REQ_WDATA[15:0]}};
      end
      default: begin
        w_st_be   = 4'hF;
        w_st_data = REQ_WDATA;
      end
    endcase
  end

  // Load extraction and extension from the returned memory word.
  always_comb begin
    w_byte = MEM_DATA_IN[{r_alo, 3'b000} +: 8];
    w_half = r_alo[1] ? MEM_DATA_IN[31:16] : MEM_DATA_IN[15:0];
    case (r_f3[1:0])
      2'b00:   w_load = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_f3[2] & w_half[15]}}, w_half};
      default: w_load = MEM_DATA_IN;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and the combinational pipeline stall.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_req;
        if (w_req) w_next = (w_illegal || w_misalign) ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        w_stall = 1'b1;
        if (!MEM_BUSYWAIT || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, memory strobes, busy counter and result registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt       <= 8'd0;
      r_f3        <= 3'd0;
      r_alo       <= 2'd0;
      r_load      <= 1'b0;
      r_rdata     <= 32'd0;
      r_rvalid    <= 1'b0;
      r_fault     <= 2'b00;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_byte_en   <= 4'd0;
      r_data_out  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_f3   <= REQ_FUNCT3;
            r_alo  <= REQ_ADDR[1:0];
            r_load <= REQ_READ;
            if (w_illegal) begin
              r_fault <= 2'b10;
            end else if (w_misalign) begin
              r_fault <= 2'b01;
            end else begin
              r_mem_read  <= REQ_READ;
              r_mem_write <= REQ_WRITE;
              r_mem_addr  <= {REQ_ADDR[31:2], 2'b00};
              r_byte_en   <= REQ_READ ? 4'hF : w_st_be;
              r_data_out  <= REQ_READ ? 32'd0 : w_st_data;
              r_cnt       <= 8'd0;
            end
          end
        end
        S_ACCESS: begin
          if (!MEM_BUSYWAIT) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_load) begin
              r_rdata  <= w_load;
              r_rvalid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_fault     <= 2'b11;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_fault  <= 2'b00;
          r_rvalid <= 1'b0;
        end
        default: begin
          r_fault  <= 2'b00;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  assign STALL        = w_stall;
  assign RDATA        = r_rdata;
  assign RVALID       = r_rvalid;
  assign FAULT        = r_fault;
  assign MEM_READ     = r_mem_read;
  assign MEM_WRITE    = r_mem_write;
  assign MEM_ADDRESS  = r_mem_addr;
  assign MEM_BYTE_EN  = r_byte_en;
  assign MEM_DATA_OUT = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit: transaction-level
//               reference model compared every cycle, plus literal vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ_READ, REQ_WRITE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR, REQ_WDATA, MEM_DATA_IN;
  logic        STALL, RVALID, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [31:0] RDATA, MEM_ADDRESS, MEM_DATA_OUT;
  logic [1:0]  FAULT;
  logic [3:0]  MEM_BYTE_EN;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  // memory busy behaviour: busy for busy_len strobed edges after busy_base
  int busy_used = 0;
  int busy_base = 0;
  int busy_len  = 0;

  always #5 CLK = ~CLK;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && ((busy_used - busy_base) < busy_len);

  always @(posedge CLK) if (MEM_BUSYWAIT) busy_used <= busy_used + 1;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_READ(REQ_READ), .REQ_WRITE(REQ_WRITE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .STALL(STALL), .RDATA(RDATA), .RVALID(RVALID), .FAULT(FAULT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_BYTE_EN(MEM_BYTE_EN), .MEM_DATA_OUT(MEM_DATA_OUT),
    .MEM_DATA_IN(MEM_DATA_IN), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic logic [1:0] spec_fault(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (rd && wr) return 2'b10;
    if (wr && f3 > 3'd2) return 2'b10;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b10;
    sz = 1 << f3[1:0];
    if ((a % sz) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] lane_en(logic [2:0] f3, logic [31:0] a);
    int sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] lane_data(logic [2:0] f3, logic [31:0] wd);
    logic [31:0] r;
    int sz = 1 << f3[1:0];
    for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(logic [31:0] w, logic [2:0] f3, logic [31:0] a);
    int sz = 1 << f3[1:0];
    int off = (a % 4) - ((a % 4) % sz);
    logic [31:0] v = w >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  int          m_phase;   // 0 waiting for request, 1 memory transfer, 2 result cycle
  int          m_nbusy;
  bit          m_rd, m_wr, m_load, m_rvalid;
  logic [1:0]  m_fault;
  logic [2:0]  m_f3;
  logic [31:0] m_a, m_rdata, m_maddr, m_dout;
  logic [3:0]  m_be;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_phase <= 0; m_nbusy <= 0; m_rd <= 0; m_wr <= 0; m_load <= 0;
      m_rvalid <= 0; m_fault <= 0; m_rdata <= 0; m_maddr <= 0; m_be <= 0; m_dout <= 0;
      m_f3 <= 0; m_a <= 0;
    end else begin
      case (m_phase)
        0: if (REQ_READ || REQ_WRITE) begin
          if (spec_fault(REQ_READ, REQ_WRITE, REQ_FUNCT3, REQ_ADDR) != 2'b00) begin
            m_phase <= 2;
            m_fault <= spec_fault(REQ_READ, REQ_WRITE, REQ_FUNCT3, REQ_ADDR);
          end else begin
            m_phase <= 1; m_nbusy <= 0;
            m_rd <= REQ_READ; m_wr <= REQ_WRITE; m_load <= REQ_READ;
            m_f3 <= REQ_FUNCT3; m_a <= REQ_ADDR;
            m_maddr <= REQ_ADDR & 32'hFFFFFFFC;
            m_be    <= REQ_READ ? 4'hF : lane_en(REQ_FUNCT3, REQ_ADDR);
            m_dout  <= lane_data(REQ_FUNCT3, REQ_WDATA);
          end
        end
        1: if (!MEM_BUSYWAIT) begin
          m_phase <= 2; m_rd <= 0; m_wr <= 0;
          if (m_load) begin
            m_rdata  <= extract(MEM_DATA_IN, m_f3, m_a);
            m_rvalid <= 1;
          end
        end else if (m_nbusy + 1 >= TO) begin
          m_phase <= 2; m_rd <= 0; m_wr <= 0; m_fault <= 2'b11;
        end else begin
          m_nbusy <= m_nbusy + 1;
        end
        default: begin
          m_phase <= 0; m_fault <= 0; m_rvalid <= 0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (!RESET && cmp_en) begin
      chk("STALL",  32'(STALL), 32'(m_phase == 1 || (m_phase == 0 && (REQ_READ || REQ_WRITE))));
      chk("MEM_READ",  32'(MEM_READ),  32'(m_rd));
      chk("MEM_WRITE", 32'(MEM_WRITE), 32'(m_wr));
      chk("RVALID", 32'(RVALID), 32'(m_rvalid));
      chk("FAULT",  32'(FAULT),  32'(m_fault));
      chk("RDATA",  RDATA, m_rdata);
      if (m_rd || m_wr) begin
        chk("MEM_ADDRESS", MEM_ADDRESS, m_maddr);
        chk("MEM_BYTE_EN", 32'(MEM_BYTE_EN), 32'(m_be));
      end
      if (m_wr) chk("MEM_DATA_OUT", MEM_DATA_OUT, m_dout);
    end
  end

  // ---------------- directed stimulus ----------------
  int          stalls;
  bit          saw_rd, saw_wr;
  logic [31:0] s_addr, s_dout;
  logic [3:0]  s_be;

  // Issue one request, hold it for the accepting edge, then run to the result cycle.
  task automatic do_req(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] mw, input int nbusy);
    @(posedge CLK); #1;
    busy_base = busy_used; busy_len = nbusy; MEM_DATA_IN = mw;
    REQ_READ = rd; REQ_WRITE = wr; REQ_FUNCT3 = f3; REQ_ADDR = a; REQ_WDATA = wd;
    stalls = 0; saw_rd = 0; saw_wr = 0; s_addr = 0; s_be = 0; s_dout = 0;
    #1 if (STALL) stalls++;
    @(posedge CLK); #1;
    REQ_READ = 0; REQ_WRITE = 0;
    for (int i = 0; i < 300; i++) begin
      if (!STALL) break;
      if (i == 0) begin s_addr = MEM_ADDRESS; s_be = MEM_BYTE_EN; s_dout = MEM_DATA_OUT; end
      saw_rd |= MEM_READ; saw_wr |= MEM_WRITE;
      stalls++;
      @(posedge CLK); #1;
      if (i == 299) chk("wait_bound", 32'(STALL), 32'd0);
    end
  endtask

  initial begin
    RESET = 1; REQ_READ = 0; REQ_WRITE = 0; REQ_FUNCT3 = 0; REQ_ADDR = 0;
    REQ_WDATA = 0; MEM_DATA_IN = 0;
    repeat (2) @(posedge CLK); #1;
    chk("rst_STALL", 32'(STALL), 0);
    chk("rst_RDATA", RDATA, 0);
    chk("rst_FAULT", 32'(FAULT), 0);
    chk("rst_MEM_READ", 32'(MEM_READ), 0);
    chk("rst_RVALID", 32'(RVALID), 0);
    RESET = 0; cmp_en = 1;

    // LW with three busy edges
    do_req(1, 0, 3'b010, 32'h10, 0, 32'h8899AABB, 3);
    chk("lw_stall_cycles", stalls, 5);
    chk("lw_rdata", RDATA, 32'h8899AABB);
    chk("lw_rvalid", 32'(RVALID), 1);
    chk("lw_addr", s_addr, 32'h10);
    chk("lw_be", 32'(s_be), 32'hF);
    @(posedge CLK); #1;
    chk("lw_rvalid_pulse", 32'(RVALID), 0);

    // Sub-word loads, zero-wait memory
    do_req(1, 0, 3'b000, 32'h13, 0, 32'h8899AABB, 0);
    chk("lb_rdata", RDATA, 32'hFFFFFF88);
    chk("min_latency", stalls, 2);
    do_req(1, 0, 3'b100, 32'h13, 0, 32'h8899AABB, 0);
    chk("lbu_rdata", RDATA, 32'h00000088);
    do_req(1, 0, 3'b001, 32'h12, 0, 32'h8899AABB, 0);
    chk("lh_rdata", RDATA, 32'hFFFF8899);
    do_req(1, 0, 3'b101, 32'h10, 0, 32'h8899AABB, 0);
    chk("lhu_rdata", RDATA, 32'h0000AABB);

    // Stores
    do_req(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 0, 0);
    chk("sh_addr", s_addr, 32'h20);
    chk("sh_be", 32'(s_be), 32'hC);
    chk("sh_dout", s_dout, 32'hABCDABCD);
    chk("sh_strobe", 32'(saw_wr), 1);
    chk("sh_no_rvalid", 32'(RVALID), 0);
    chk("sh_rdata_held", RDATA, 32'h0000AABB);
    do_req(0, 1, 3'b000, 32'h21, 32'h1234ABCD, 0, 0);
    chk("sb_be", 32'(s_be), 32'h2);
    chk("sb_dout", s_dout, 32'hCDCDCDCD);
    do_req(0, 1, 3'b010, 32'h08, 32'hCAFEF00D, 0, 1);
    chk("sw_be", 32'(s_be), 32'hF);
    chk("sw_dout", s_dout, 32'hCAFEF00D);

    // Faults
    do_req(1, 0, 3'b010, 32'h06, 0, 32'h8899AABB, 0);
    chk("lw_mis_fault", 32'(FAULT), 1);
    chk("lw_mis_noread", 32'(saw_rd | MEM_READ), 0);
    chk("lw_mis_stall", stalls, 1);
    @(posedge CLK); #1;
    chk("fault_one_cycle", 32'(FAULT), 0);
    do_req(1, 1, 3'b010, 32'h10, 0, 0, 0);
    chk("rdwr_fault", 32'(FAULT), 2);
    do_req(0, 1, 3'b101, 32'h10, 0, 0, 0);
    chk("sbu_fault", 32'(FAULT), 2);
    do_req(1, 0, 3'b011, 32'h10, 0, 0, 0);
    chk("ld011_fault", 32'(FAULT), 2);
    do_req(1, 0, 3'b001, 32'h11, 0, 0, 0);
    chk("lh_mis_fault", 32'(FAULT), 1);

    // Timeout with busy stuck high
    do_req(1, 0, 3'b010, 32'h40, 0, 32'h11223344, 100000);
    chk("to_stall_cycles", stalls, 65);
    chk("to_fault", 32'(FAULT), 3);
    chk("to_mem_read", 32'(MEM_READ), 0);
    chk("to_rvalid", 32'(RVALID), 0);
    chk("to_rdata_held", RDATA, 32'h0000AABB);
    busy_len = 0;

    // Reset in the middle of an access
    @(posedge CLK); #1;
    busy_base = busy_used; busy_len = 100000;
    REQ_READ = 1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h40;
    @(posedge CLK); #1;
    REQ_READ = 0;
    @(posedge CLK); #2;
    chk("pre_rst_read", 32'(MEM_READ), 1);
    RESET = 1;
    #1;
    chk("rst_mid_read", 32'(MEM_READ), 0);
    chk("rst_mid_rvalid", 32'(RVALID), 0);
    chk("rst_mid_fault", 32'(FAULT), 0);
    chk("rst_mid_stall", 32'(STALL), 0);
    @(posedge CLK); #1;
    busy_len = 0; RESET = 0;
    do_req(1, 0, 3'b010, 32'h10, 0, 32'h8899AABB, 0);
    chk("post_rst_rdata", RDATA, 32'h8899AABB);
    chk("post_rst_rvalid", 32'(RVALID), 1);

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
